// File: rtl/router_ilck_arbiter.sv
// ---------------------------------------------------------------------------
// router_ilck_arbiter
//
// Round-robin input-lock arbiter for one router output channel. It picks one
// of NUM_IN requesting input ports and keeps that port locked onto the output
// until the port's tail flit transfers or the owner has stalled for TIMEOUT
// cycles. grant, grant_idx and locked are registered and drive the slice's
// ILCK lock flops and the output mux select directly.
//
// Handshake: a flit moves on cycle c exactly when xfer is high on cycle c,
// that is, when the port is locked, the owner's req is high (valid) and
// out_ready is high (ready). Neither side may make valid depend on ready.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   req[NUM_IN]    per-port flit valid, held while a flit is pending
//   tail[NUM_IN]   per-port "current flit is the packet's last"
//   out_ready      downstream accepts a flit this cycle
//   grant[NUM_IN]  registered one-hot grant (all-zero when idle)
//   grant_idx      registered owner index (0 when idle)
//   locked         registered, high while a port owns the output
//   xfer           combinational flit-transfer strobe
//   timeout_pulse  registered one-cycle pulse on a forced release
//   state_dbg      current FSM state (0 = IDLE, 1 = LOCKED)
// ---------------------------------------------------------------------------
module router_ilck_arbiter #(
    parameter int NUM_IN  = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] req,
    input  logic [NUM_IN-1:0] tail,
    input  logic              out_ready,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              locked,
    output logic              xfer,
    output logic              timeout_pulse,
    output logic              state_dbg
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    // The stall counter releases the lock on the cycle it would reach
    // TIMEOUT, so the comparison is against TIMEOUT-1 of the current value.
    localparam logic [7:0]        STALL_LAST = 8'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  PTR_RESET  = IDX_W'(NUM_IN - 1);
    localparam logic [NUM_IN-1:0] ONE_HOT0   = NUM_IN'(1);

    state_t            state;
    logic [IDX_W-1:0]  ptr;        // last owner; scan starts just after it
    logic [7:0]        stall_cnt;  // saturating count of owner-idle cycles

    logic              owner_req;
    logic              owner_tail;
    logic              found;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  cand;

    assign owner_req  = req[grant_idx];
    assign owner_tail = tail[grant_idx];

    // grant_idx is 0 when unlocked, so gating with locked keeps xfer low
    // while idle even if port 0 is requesting.
    assign xfer      = locked & owner_req & out_ready;
    assign state_dbg = (state == S_LOCKED);

    // Round-robin pick: first requesting port at ptr+1, ptr+2, ... mod NUM_IN.
    // ptr itself is scanned last, so the previous owner has lowest priority.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_IN);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            grant         <= '0;
            grant_idx     <= '0;
            locked        <= 1'b0;
            timeout_pulse <= 1'b0;
            ptr           <= PTR_RESET;
            stall_cnt     <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state     <= S_LOCKED;
                        grant     <= ONE_HOT0 << sel;
                        grant_idx <= sel;
                        locked    <= 1'b1;
                        stall_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (owner_tail) begin
                            // Packet complete: release and remember the owner.
                            state     <= S_IDLE;
                            grant     <= '0;
                            grant_idx <= '0;
                            locked    <= 1'b0;
                            ptr       <= grant_idx;
                        end
                    end else if (!owner_req) begin
                        if (stall_cnt >= STALL_LAST) begin
                            // Owner went quiet too long: force the release.
                            state         <= S_IDLE;
                            grant         <= '0;
                            grant_idx     <= '0;
                            locked        <= 1'b0;
                            ptr           <= grant_idx;
                            timeout_pulse <= 1'b1;
                        end else if (stall_cnt != 8'hFF) begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end
                    // Owner valid but out_ready low is backpressure: the
                    // stall counter neither advances nor clears.
                end
            endcase
        end
    end

endmodule

// File: doc/router_ilck_arbiter.md
# router_ilck_arbiter

Round-robin input-lock arbiter for the router_wrap slice. It shares one router output channel among NUM_IN input ports. Once it grants a port, it holds that grant (the input lock) until the port's tail flit transfers or an idle timeout expires. Its grant/lock outputs are the registered values that drive the slice's ILCK lock flip-flops and the output mux select.

## Interface
Parameters:
- NUM_IN, default 4: number of requesting input ports, range 2..16.
- IDX_W, default 2: width of the owner index, equal to clog2(NUM_IN).
- TIMEOUT, default 15: number of consecutive stalled-owner cycles that force a lock release, range 1..255.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- req, input, NUM_IN: per-port flit valid; a port holds req high while it has a flit pending.
- tail, input, NUM_IN: per-port "current flit is the last of its packet"; only meaningful with req.
- out_ready, input, 1: the downstream output channel accepts a flit this cycle.
- grant, output, NUM_IN: registered grant, one-hot or all-zero.
- grant_idx, output, IDX_W: registered index of the owner; 0 when no port is locked.
- locked, output, 1: registered; high while a port owns the output.
- xfer, output, 1: combinational, equal to locked & req[grant_idx] & out_ready. It marks a flit transfer this cycle.
- timeout_pulse, output, 1: registered one-cycle pulse when a lock is force-released.

## Operation
- Two states: IDLE and LOCKED. A round-robin pointer `ptr` (IDX_W bits) stores the last owner.
- **IDLE:**
  - If any req bit is set, select the first set bit scanning ptr+1, ptr+2, … modulo NUM_IN.
  - Register it: grant = onehot(sel), grant_idx = sel, locked = 1, go to LOCKED.
  - If no req bit is set, stay in IDLE with all outputs at 0.
- **LOCKED:**
  - On xfer & tail[grant_idx], release: clear grant and locked, set grant_idx = 0, set ptr = owner, go to IDLE.
  - On xfer & !tail[grant_idx], hold the grant and clear the stall counter.
  - While req[grant_idx] = 0, increment the stall counter (8 bits, saturating).
  - When req[grant_idx] = 0 and the counter reaches TIMEOUT, release exactly as on a tail transfer and assert timeout_pulse for 1 cycle.
  - Cycles with req[grant_idx] = 1 and out_ready = 0 are backpressure, not a stall. They do not increment the counter and do not clear it.
  - Requests from other ports are ignored while locked.
- The stall counter clears on entry to LOCKED and on every xfer.
- Release and re-arbitration never happen in the same cycle. After a release there is always at least one IDLE cycle, so a released port cannot be regranted before other waiting ports get their turn.
- A single-flit packet (req & tail in the granted cycle) takes exactly one LOCKED cycle when out_ready = 1.
- Reset values:
  - grant = 0, grant_idx = 0, locked = 0, timeout_pulse = 0.
  - Stall counter = 0, state = IDLE.
  - ptr = NUM_IN-1, so input 0 has first priority.
- Reset in the middle of a packet drops the lock immediately. No tail is required afterwards, and no timeout_pulse is generated.

## Timing
- Arbitration latency: a req first seen in IDLE at cycle N gives grant/locked high at cycle N+1. The first possible xfer is at cycle N+1.
- Release: a tail xfer at cycle M gives locked = 0 at M+1. The earliest new grant is M+2.
- Timeout: the owner drops req at cycle S and keeps it low. The counter reaches TIMEOUT at the end of cycle S+TIMEOUT-1. locked falls and timeout_pulse rises at S+TIMEOUT, and timeout_pulse is low again at S+TIMEOUT+1.
- If the owner reasserts req before the timeout, the counter is not cleared until the next xfer.
- xfer is purely combinational from req, out_ready and the registered state. There is no path from req to grant within the same cycle.
- Sustained throughput: for K-flit packets with out_ready always high, each packet occupies K+1 cycles (K LOCKED cycles plus 1 IDLE cycle).

## Test plan
1. **Reset and single port.** Reset; hold req = 0010 with tail on the 3rd flit and out_ready = 1. Required: grant = 0010 and grant_idx = 1 one cycle after req. xfer is high for 3 cycles, then locked = 0. The next grant is no earlier than 2 cycles after the tail.
2. **Round-robin fairness.** req = 1111 constantly, every flit a tail. Required: grants in order 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between grants.
3. **Lock hold and backpressure.** Port 2 is locked on a 4-flit packet and port 0 requests throughout. out_ready = 0 for 5 cycles mid-packet. Required: grant stays 0100, xfer is low during the stall, no timeout occurs, port 0 is granted only after port 2's tail.
4. **Timeout.** TIMEOUT = 4. Port 3 is granted and then drops req with no tail. Required: locked falls and timeout_pulse is high for 1 cycle exactly 4 cycles after req drops; ptr = 3, so a waiting port 0 is granted next.
5. **Reset mid-packet.** Assert reset for 1 cycle while port 1 is locked with 2 flits remaining, and keep req = 0011. Required: all outputs are 0 in the cycle after reset; the next grant is 0001 (port 0 has priority again) and no timeout_pulse occurs.
6. **Single-flit boundary.** req = 0100 and tail = 0100 held high. Required: the grant pattern repeats LOCKED, IDLE, LOCKED, …, with exactly one xfer per LOCKED cycle and grant_idx = 2 on every grant.
